// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch (I) and load/store (D) with starvation guard.
// Optional MEM_ARB_PERF_EN adds grant/conflict performance counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_conflicts
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t     r_state;
  logic [3:0] r_starve;
  logic [3:0] r_lat;
  logic       r_owner_d;
  logic       w_idle;
  logic       w_i_win;
  logic       w_i_acc;
  logic       w_d_acc;
  logic       w_acc;
  logic       w_sample;
  assign w_idle   = r_state == IDLE && !rst;
  assign w_i_win  = i_req && (!d_req || r_starve == 4'(STARVE_MAX));
  assign w_i_acc  = w_idle && w_i_win;
  assign w_d_acc  = w_idle && d_req && !w_i_win;
  assign w_acc    = w_i_acc || w_d_acc;
  // Read data lands at the end of cycle accept+MEM_LAT; with MEM_LAT==1 that is the ISSUE cycle itself.
  assign w_sample = (r_state == ISSUE && !mem_we && MEM_LAT == 1) || (r_state == WAIT && r_lat == 4'd0);
  assign i_ready  = w_i_acc;
  assign d_ready  = w_d_acc;
  assign busy     = r_state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_starve  <= '0;
      r_lat     <= '0;
      r_owner_d <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      mem_en   <= w_acc;
      mem_we   <= w_d_acc && d_we;
      i_rvalid <= w_sample && !r_owner_d;
      d_rvalid <= w_sample && r_owner_d;
      if (w_acc) begin
        r_owner_d <= w_d_acc;
        mem_addr  <= w_d_acc ? d_addr : i_addr;
        r_starve  <= w_i_acc ? 4'd0 : (i_req ? r_starve + 4'd1 : r_starve);
      end
      if (w_d_acc) mem_wdata <= d_wdata;
      if (w_sample && r_owner_d) d_rdata <= mem_rdata;
      if (w_sample && !r_owner_d) i_rdata <= mem_rdata;
      case (r_state)
        IDLE: r_state <= w_acc ? ISSUE : IDLE;
        ISSUE: begin
          r_state <= mem_we ? IDLE : (MEM_LAT == 1 ? RESP : WAIT);
          r_lat   <= 4'(MEM_LAT - 2);
        end
        WAIT: begin
          r_state <= r_lat == 4'd0 ? RESP : WAIT;
          r_lat   <= r_lat == 4'd0 ? r_lat : r_lat - 4'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      perf_i_grants  <= perf_i_grants + 32'(w_i_acc);
      perf_d_grants  <= perf_d_grants + 32'(w_d_acc);
      perf_conflicts <= perf_conflicts + 32'(w_idle && i_req && d_req);
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, corner sequences and a randomized transaction-level model check.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  localparam int NR  = 1500;
  localparam int NA  = NR + 8;
  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic [31:0] rd;
    logic [6:0]  fl;
    logic [31:0] ma;
    logic [31:0] mw;
    logic [31:0] ird;
    logic [31:0] drd;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic i_ready, i_rvalid, d_ready, d_rvalid, mem_en, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic l1_i_ready, l1_i_rvalid, l1_d_ready, l1_d_rvalid, l1_mem_en, l1_mem_we, l1_busy;
  logic [31:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;
  logic [31:0] l1_pi, l1_pd, l1_pc;
`endif
  logic [134:0] obs;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(3)) u_dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_PERF_EN
    , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants), .perf_conflicts(perf_conflicts)
`endif
  );
  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) u_l1 (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_ready(l1_i_ready), .i_rvalid(l1_i_rvalid),
    .i_rdata(l1_i_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(l1_d_ready),
    .d_rvalid(l1_d_rvalid), .d_rdata(l1_d_rdata), .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(mem_rdata), .busy(l1_busy)
`ifdef MEM_ARB_PERF_EN
    , .perf_i_grants(l1_pi), .perf_d_grants(l1_pd), .perf_conflicts(l1_pc)
`endif
  );
  assign obs = {i_ready, d_ready, mem_en, mem_we, busy, i_rvalid, d_rvalid, mem_addr, mem_wdata, i_rdata, d_rdata};

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                              input logic [31:0] da, input logic [31:0] dd, input logic [31:0] rd,
                              input logic [6:0] fl, input logic [31:0] ma, input logic [31:0] mw,
                              input logic [31:0] ird, input logic [31:0] drd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.rd = rd;
    v.fl = fl; v.ma = ma; v.mw = mw; v.ird = ird; v.drd = drd;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; mem_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    check("reset_state", 160'(obs), 160'(0));
    @(posedge clk); #1;
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
  endtask

  // Transaction-level reference: per-cycle schedules derived from accept time and MEM_LAT.
  logic en_at[NA], we_at[NA], iv_at[NA], dv_at[NA];
  logic [31:0] addr_at[NA], wd_at[NA], rd_hist[NA];

  initial begin
    vec_t tbl[16];
    logic [7:0]  order;
    logic [11:0] acc, rv;
    int ng, both, nd, k, free_at, starve, pi, pd, pc;
    logic idle, ea_i, ea_d;
    logic [31:0] m_ma, m_mw, m_ird, m_drd;
    //            ir ia      dr dw da      dd      rd            fl          ma      mw      ird           drd
    tbl[0]  = mk(1, 32'h10, 0, 0, 0,      0,      0,            7'b1000000, 0,      0,      0,            0);
    tbl[1]  = mk(0, 0,      0, 0, 0,      0,      0,            7'b0010100, 32'h10, 0,      0,            0);
    tbl[2]  = mk(0, 0,      0, 0, 0,      0,      32'hDEADBEEF, 7'b0000100, 32'h10, 0,      0,            0);
    tbl[3]  = mk(0, 0,      0, 0, 0,      0,      0,            7'b0000110, 32'h10, 0,      32'hDEADBEEF, 0);
    tbl[4]  = mk(1, 32'h14, 0, 0, 0,      0,      0,            7'b1000000, 32'h10, 0,      32'hDEADBEEF, 0);
    tbl[5]  = mk(0, 0,      0, 0, 0,      0,      0,            7'b0010100, 32'h14, 0,      32'hDEADBEEF, 0);
    tbl[6]  = mk(0, 0,      0, 0, 0,      0,      32'h12345678, 7'b0000100, 32'h14, 0,      32'hDEADBEEF, 0);
    tbl[7]  = mk(0, 0,      0, 0, 0,      0,      0,            7'b0000110, 32'h14, 0,      32'h12345678, 0);
    tbl[8]  = mk(0, 0,      1, 1, 32'h20, 32'h55, 0,            7'b0100000, 32'h14, 0,      32'h12345678, 0);
    tbl[9]  = mk(0, 0,      0, 0, 0,      0,      0,            7'b0011100, 32'h20, 32'h55, 32'h12345678, 0);
    tbl[10] = mk(0, 0,      0, 0, 0,      0,      0,            7'b0000000, 32'h20, 32'h55, 32'h12345678, 0);
    tbl[11] = mk(0, 0,      1, 0, 32'h24, 32'h77, 0,            7'b0100000, 32'h20, 32'h55, 32'h12345678, 0);
    tbl[12] = mk(0, 0,      0, 0, 0,      0,      0,            7'b0010100, 32'h24, 32'h77, 32'h12345678, 0);
    tbl[13] = mk(0, 0,      0, 0, 0,      0,      32'hCAFEF00D, 7'b0000100, 32'h24, 32'h77, 32'h12345678, 0);
    tbl[14] = mk(0, 0,      0, 0, 0,      0,      0,            7'b0000101, 32'h24, 32'h77, 32'h12345678, 32'hCAFEF00D);
    tbl[15] = mk(0, 0,      0, 0, 0,      0,      0,            7'b0000000, 32'h24, 32'h77, 32'h12345678, 32'hCAFEF00D);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      i_req = tbl[i].ir; i_addr = tbl[i].ia; d_req = tbl[i].dr; d_we = tbl[i].dw;
      d_addr = tbl[i].da; d_wdata = tbl[i].dd; mem_rdata = tbl[i].rd;
      @(negedge clk);
      check($sformatf("vec%0d", i), 160'(obs), 160'({tbl[i].fl, tbl[i].ma, tbl[i].mw, tbl[i].ird, tbl[i].drd}));
      @(posedge clk); #1;
    end
    // Continuous conflict: D wins three times, then the starved fetch is forced through.
    do_reset();
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h100; d_addr = 32'h200; mem_rdata = 32'hA5A5A5A5;
    order = '0; ng = 0; both = 0; k = 0;
    while (ng < 8 && k < 100) begin
      @(negedge clk);
      if (i_ready && d_ready) both++;
      if (i_ready || d_ready) begin order[ng] = i_ready; ng++; end
      @(posedge clk); #1;
      k++;
    end
    check("starve_grants", 160'(ng), 160'(8));
    check("starve_order", 160'(order), 160'(8'b1000_1000));
    check("ready_exclusive", 160'(both), 160'(0));
    // Build starvation up to the limit, then reset during the WAIT of a D load.
    nd = 0; k = 0;
    while (nd < 3 && k < 80) begin
      @(negedge clk);
      if (d_ready && i_req) nd++;
      @(posedge clk); #1;
      k++;
    end
    check("rw_dgrants", 160'(nd), 160'(3));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_wait", 160'(obs), 160'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_starve_clr", 160'({i_ready, d_ready, d_rvalid}), 160'(3'b010));
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    // Unit-latency instance: back-to-back loads three cycles apart with single-cycle rvalid.
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      acc[i] = l1_d_ready; rv[i] = l1_d_rvalid;
      @(posedge clk); #1;
    end
    check("lat1_accepts", 160'(acc), 160'(12'h249));
    check("lat1_rvalid", 160'(rv), 160'(12'h924));
    // Randomized traffic against the schedule model.
    do_reset();
    for (int i = 0; i < NA; i++) begin
      en_at[i] = 0; we_at[i] = 0; iv_at[i] = 0; dv_at[i] = 0; addr_at[i] = 0; wd_at[i] = 0; rd_hist[i] = 0;
    end
    free_at = 0; starve = 0; pi = 0; pd = 0; pc = 0;
    m_ma = 0; m_mw = 0; m_ird = 0; m_drd = 0;
    for (int c = 0; c < NR; c++) begin
      if (!i_req && $urandom_range(2) == 0) begin i_req = 1'b1; i_addr = $urandom; end
      if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom;
      end
      mem_rdata = $urandom;
      rd_hist[c] = mem_rdata;
      @(negedge clk);
      idle = c >= free_at;
      ea_i = idle && i_req && (!d_req || starve == 3);
      ea_d = idle && d_req && !ea_i;
      if (en_at[c]) begin m_ma = addr_at[c]; m_mw = wd_at[c]; end
      if (iv_at[c]) m_ird = rd_hist[c-1];
      if (dv_at[c]) m_drd = rd_hist[c-1];
      check($sformatf("rand_c%0d", c), 160'(obs),
            160'({ea_i, ea_d, en_at[c], we_at[c], c < free_at, iv_at[c], dv_at[c], m_ma, m_mw, m_ird, m_drd}));
      if (idle && i_req && d_req) pc++;
      if (ea_i || ea_d) begin
        en_at[c+1] = 1'b1;
        we_at[c+1] = ea_d && d_we;
        addr_at[c+1] = ea_d ? d_addr : i_addr;
        wd_at[c+1] = ea_d ? d_wdata : m_mw;
        if (ea_d && d_we) free_at = c + 2;
        else begin
          free_at = c + LAT + 2;
          if (ea_i) iv_at[c+LAT+1] = 1'b1;
          else dv_at[c+LAT+1] = 1'b1;
        end
        if (ea_i) begin starve = 0; pi++; end
        else begin pd++; if (i_req) starve++; end
      end
      @(posedge clk); #1;
      if (ea_i) i_req = 1'b0;
      if (ea_d) d_req = 1'b0;
    end
`ifdef MEM_ARB_PERF_EN
    check("perf_i_grants", 160'(perf_i_grants), 160'(pi));
    check("perf_d_grants", 160'(perf_d_grants), 160'(pd));
    check("perf_conflicts", 160'(perf_conflicts), 160'(pc));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
